msg_uart_tx: RTL

- Reader end of the decrypted-message RAM; today that RAM is written by the decrypt FSM and never read back.
- On a start pulse (e.g. the brute-force `solved` flag), the block reads MSG_LEN bytes from the RAM's read port in address order.
- Each byte is sent as an 8N1 UART frame on one TX pin, so the recovered plaintext can be read on a host terminal.
- Sits beside the memory handler; it owns the RAM address only while `mem_req` is high.

---
 rtl/msg_uart_pkg.sv | 25 ++
 rtl/msg_uart_tx_byte.sv | 69 ++++++
 rtl/msg_uart_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/msg_uart_pkg.sv
// Shared definitions for the message UART transmitter.
// Holds the sequencer state type, the UART frame geometry, the line-ending
// characters used by the optional CR/LF trailer, and the default bit period.
package msg_uart_pkg;

    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // start + 8 data + stop
    localparam int UART_FRAME_BITS = 10;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CAP,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/msg_uart_tx_byte.sv
// uart_tx_byte: single-byte 8N1 serializer.
// A load pulse latches byte_in and starts a frame on the next cycle:
// start bit (0), eight data bits LSB first, stop bit (1), each bit
// CLKS_PER_BIT cycles long.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (tx returns to idle high)
//   load       one-cycle request to send byte_in; only issued while idle
//   byte_in    byte to send, sampled on load
//   tx         serial output, idles high
//   byte_done  one-cycle pulse during the last cycle of the stop bit
module uart_tx_byte
    import msg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic          active;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    // data bits followed by the stop bit; shifted out LSB first after start
    logic [8:0]    shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
        end else if (load) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= {1'b1, byte_in};
            tx      <= 1'b0;
        end else if (active) begin
            if (clk_cnt == CLK_LAST) begin
                clk_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

    assign byte_done = active && (bit_cnt == BIT_LAST) && (clk_cnt == CLK_LAST);

endmodule

// File: rtl/msg_uart_tx.sv
// msg_uart_tx: reads MSG_LEN bytes from the decrypted-message RAM in address
// order and sends each one as an 8N1 UART frame on tx.
// Optional build macro MSG_UART_TX_CRLF_EN appends a CR, LF trailer after the
// message (RAM released before the CR frame).
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     one-cycle transfer request, honoured only in IDLE
//   mem_q     RAM read data, valid the cycle after mem_addr is sampled
//   mem_addr  RAM read address (registered)
//   mem_req   high while this block owns the RAM read port
//   tx        UART serial output, idles high
//   busy      high from leaving IDLE until DONE is entered
//   done      one-cycle pulse after the last stop bit
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// RD      | mem_addr presented to the RAM
// WAIT    | RAM read latency
// CAP     | mem_q (or trailer char) handed to the serializer
// SEND    | frame on the wire, wait for byte_done
// NEXT    | advance address, or finish
// DONE    | done pulse, release RAM
module msg_uart_tx
    import msg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MSG_LEN      = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Termination is by compare against the last address, so MSG_LEN equal
    // to 2**ADDR_W ends on all-ones without ever wrapping the address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              req_q, req_nxt;
    logic              busy_q, busy_nxt;
    logic              load;
    logic [7:0]        tx_byte;
    logic              byte_done;

`ifdef MSG_UART_TX_CRLF_EN
    localparam logic [1:0] TAIL_NONE = 2'd0;
    localparam logic [1:0] TAIL_CR   = 2'd1;
    localparam logic [1:0] TAIL_LF   = 2'd2;

    logic [1:0] tail_q, tail_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MSG_UART_TX_CRLF_EN
            tail_q  <= TAIL_NONE;
`endif
        end else begin
            state_q <= state_nxt;
            addr_q  <= addr_nxt;
            req_q   <= req_nxt;
            busy_q  <= busy_nxt;
`ifdef MSG_UART_TX_CRLF_EN
            tail_q  <= tail_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        req_nxt   = req_q;
        busy_nxt  = busy_q;
        load      = 1'b0;
        done      = 1'b0;
        tx_byte   = mem_q;
`ifdef MSG_UART_TX_CRLF_EN
        tail_nxt  = tail_q;
        case (tail_q)
            TAIL_CR: tx_byte = ASCII_CR;
            TAIL_LF: tx_byte = ASCII_LF;
            default: tx_byte = mem_q;
        endcase
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    req_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_RD;
`ifdef MSG_UART_TX_CRLF_EN
                    tail_nxt  = TAIL_NONE;
`endif
                end
            end
            ST_RD:   state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_CAP;
            ST_CAP: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (byte_done) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
`ifdef MSG_UART_TX_CRLF_EN
                if (tail_q == TAIL_LF) begin
                    busy_nxt  = 1'b0;
                    req_nxt   = 1'b0;
                    state_nxt = ST_DONE;
                end else if (tail_q == TAIL_CR) begin
                    tail_nxt  = TAIL_LF;
                    state_nxt = ST_RD;
                end else if (addr_q == LAST_ADDR) begin
                    // trailer frames come from constants; RAM no longer needed
                    tail_nxt  = TAIL_CR;
                    req_nxt   = 1'b0;
                    state_nxt = ST_RD;
                end else begin
                    addr_nxt  = addr_q + ADDR_W'(1);
                    state_nxt = ST_RD;
                end
`else
                if (addr_q == LAST_ADDR) begin
                    busy_nxt  = 1'b0;
                    req_nxt   = 1'b0;
                    state_nxt = ST_DONE;
                end else begin
                    addr_nxt  = addr_q + ADDR_W'(1);
                    state_nxt = ST_RD;
                end
`endif
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .byte_in   (tx_byte),
        .tx        (tx),
        .byte_done (byte_done)
    );

    assign mem_addr = addr_q;
    assign mem_req  = req_q;
    assign busy     = busy_q;

endmodule
